// File: rtl/ysyx_25040129_wb_arbiter_pkg.sv
// Shared widths and port identifiers for the writeback arbiter slice.
`ifndef ysyx_25040129_REGS_DIG
`define ysyx_25040129_REGS_DIG 5
`endif
`ifndef ysyx_25040129_CSR_DIG
`define ysyx_25040129_CSR_DIG 12
`endif

package ysyx_25040129_wb_arbiter_pkg;

    localparam int unsigned REGS_DIG = `ysyx_25040129_REGS_DIG;
    localparam int unsigned CSR_DIG  = `ysyx_25040129_CSR_DIG;

    localparam int unsigned P_LSU = 0;
    localparam int unsigned P_MDU = 1;

    typedef enum logic {
        PORT_LSU = 1'(P_LSU),
        PORT_MDU = 1'(P_MDU)
    } port_e;

endpackage

// File: rtl/ysyx_25040129_wb_scoreboard.sv
// Busy bits for GPRs awaiting an out-of-order MDU result, with two query ports.
module ysyx_25040129_wb_scoreboard
    import ysyx_25040129_wb_arbiter_pkg::*;
#(
    parameter int unsigned REGS_DIG = ysyx_25040129_wb_arbiter_pkg::REGS_DIG
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                set_en,
    input  logic [REGS_DIG-1:0] set_idx,
    input  logic                clr_en,
    input  logic [REGS_DIG-1:0] clr_idx,
    input  logic [REGS_DIG-1:0] rd_idx1,
    input  logic [REGS_DIG-1:0] rd_idx2,
    output logic                rd_busy1,
    output logic                rd_busy2
);

    localparam int unsigned NREGS = 2 ** REGS_DIG;

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    // Set is applied after clear so a same-cycle reissue keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (clr_en) busy_next[clr_idx] = 1'b0;
        if (set_en) busy_next[set_idx] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= busy_next;
    end

    assign rd_busy1 = busy[rd_idx1];
    assign rd_busy2 = busy[rd_idx2];

endmodule

// File: rtl/ysyx_25040129_wb_arbiter.sv
// Round-robin arbiter between LSU/WBU (port 0) and MDU (port 1) for the shared regfile/CSR write port.
module ysyx_25040129_wb_arbiter
    import ysyx_25040129_wb_arbiter_pkg::*;
#(
    parameter int unsigned REGS_DIG = ysyx_25040129_wb_arbiter_pkg::REGS_DIG,
    parameter int unsigned CSR_DIG  = ysyx_25040129_wb_arbiter_pkg::CSR_DIG
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                p0_valid,
    output logic                p0_ready,
    input  logic [REGS_DIG-1:0] p0_rd,
    input  logic [31:0]         p0_data,
    input  logic                p0_reg_write,
    input  logic                p0_csr_write,
    input  logic [CSR_DIG-1:0]  p0_csr_addr,
    input  logic                p1_valid,
    output logic                p1_ready,
    input  logic [REGS_DIG-1:0] p1_rd,
    input  logic [31:0]         p1_data,
    input  logic                iss_valid,
    input  logic [REGS_DIG-1:0] iss_rd,
    input  logic [REGS_DIG-1:0] q_rs1,
    input  logic [REGS_DIG-1:0] q_rs2,
    output logic                q_rs1_busy,
    output logic                q_rs2_busy,
    output logic                wb_reg_write,
    output logic [REGS_DIG-1:0] wb_rd,
    output logic [31:0]         wb_data,
    output logic                wb_csr_write,
    output logic [CSR_DIG-1:0]  wb_csr_addr,
    output logic                fwd_valid
);

    port_e last_q;
    logic  grant0;
    logic  grant1;

    // Under contention the port not granted most recently wins.
    always_comb begin
        grant0 = p0_valid & (~p1_valid | (last_q == PORT_MDU));
        grant1 = p1_valid & ~grant0;
    end

    assign p0_ready = grant0;
    assign p1_ready = grant1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       last_q <= PORT_MDU;
        else if (grant0) last_q <= PORT_LSU;
        else if (grant1) last_q <= PORT_MDU;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_reg_write <= 1'b0;
            wb_csr_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_csr_addr  <= '0;
        end else if (grant0) begin
            wb_reg_write <= p0_reg_write & (p0_rd != '0);
            wb_csr_write <= p0_csr_write;
            wb_rd        <= p0_rd;
            wb_data      <= p0_data;
            wb_csr_addr  <= p0_csr_addr;
        end else if (grant1) begin
            wb_reg_write <= (p1_rd != '0);
            wb_csr_write <= 1'b0;
            wb_rd        <= p1_rd;
            wb_data      <= p1_data;
        end else begin
            wb_reg_write <= 1'b0;
            wb_csr_write <= 1'b0;
        end
    end

    assign fwd_valid = wb_reg_write;

    ysyx_25040129_wb_scoreboard #(
        .REGS_DIG (REGS_DIG)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (iss_valid),
        .set_idx  (iss_rd),
        .clr_en   (grant1),
        .clr_idx  (p1_rd),
        .rd_idx1  (q_rs1),
        .rd_idx2  (q_rs2),
        .rd_busy1 (q_rs1_busy),
        .rd_busy2 (q_rs2_busy)
    );

endmodule

// File: tb/tb_ysyx_25040129_wb_arbiter.sv
// Directed vector bench for the writeback arbiter and its MDU scoreboard.
module tb_ysyx_25040129_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        p0_valid = 1'b0, p0_reg_write = 1'b0, p0_csr_write = 1'b0;
    logic [4:0]  p0_rd = '0;
    logic [31:0] p0_data = '0;
    logic [11:0] p0_csr_addr = '0;
    logic        p1_valid = 1'b0;
    logic [4:0]  p1_rd = '0;
    logic [31:0] p1_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0, q_rs1 = '0, q_rs2 = '0;
    logic        p0_ready, p1_ready, q_rs1_busy, q_rs2_busy;
    logic        wb_reg_write, wb_csr_write, fwd_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [11:0] wb_csr_addr;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ysyx_25040129_wb_arbiter #(
        .REGS_DIG (5),
        .CSR_DIG  (12)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .p0_valid     (p0_valid),
        .p0_ready     (p0_ready),
        .p0_rd        (p0_rd),
        .p0_data      (p0_data),
        .p0_reg_write (p0_reg_write),
        .p0_csr_write (p0_csr_write),
        .p0_csr_addr  (p0_csr_addr),
        .p1_valid     (p1_valid),
        .p1_ready     (p1_ready),
        .p1_rd        (p1_rd),
        .p1_data      (p1_data),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .q_rs1        (q_rs1),
        .q_rs2        (q_rs2),
        .q_rs1_busy   (q_rs1_busy),
        .q_rs2_busy   (q_rs2_busy),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_csr_write (wb_csr_write),
        .wb_csr_addr  (wb_csr_addr),
        .fwd_valid    (fwd_valid)
    );

    typedef struct {
        logic        p0v;
        logic [4:0]  p0rd;
        logic [31:0] p0d;
        logic        p0rw;
        logic        p0cw;
        logic [11:0] p0ca;
        logic        p1v;
        logic [4:0]  p1rd;
        logic [31:0] p1d;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  qr1;
        logic [4:0]  qr2;
        logic        e_p0r;
        logic        e_p1r;
        logic        e_q1;
        logic        e_q2;
        logic        e_rw;
        logic [4:0]  e_rd;
        logic [31:0] e_d;
        logic        e_cw;
        logic [11:0] e_ca;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        p0_valid = 1'b0; p0_rd = '0; p0_data = '0; p0_reg_write = 1'b0;
        p0_csr_write = 1'b0; p0_csr_addr = '0;
        p1_valid = 1'b0; p1_rd = '0; p1_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    int wait0, wait1;
    logic exp_p0;

    initial begin
        // Readies/busy checked before the edge, wb_* checked after it.
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 12'h000, 1'b1, 5'd9,  32'h22222222, 1'b1, 5'd7,  5'd7, 5'd9,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 12'h000};
        vecs[1]  = '{1'b1, 5'd3, 32'h33333333, 1'b1, 1'b0, 12'h000, 1'b1, 5'd9,  32'h22222222, 1'b0, 5'd0,  5'd7, 5'd9,
                     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9,  32'h22222222, 1'b0, 12'h000};
        vecs[2]  = '{1'b1, 5'd3, 32'h33333333, 1'b1, 1'b0, 12'h000, 1'b1, 5'd10, 32'h44444444, 1'b1, 5'd10, 5'd7, 5'd10,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  32'h33333333, 1'b0, 12'h000};
        vecs[3]  = '{1'b1, 5'd4, 32'h55555555, 1'b1, 1'b0, 12'h000, 1'b1, 5'd10, 32'h44444444, 1'b0, 5'd0,  5'd7, 5'd10,
                     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 32'h44444444, 1'b0, 12'h000};
        vecs[4]  = '{1'b1, 5'd4, 32'h55555555, 1'b1, 1'b0, 12'h000, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7, 5'd10,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4,  32'h55555555, 1'b0, 12'h000};
        vecs[5]  = '{1'b1, 5'd0, 32'h66666666, 1'b1, 1'b1, 12'h341, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7, 5'd0,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h66666666, 1'b1, 12'h341};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 12'h000, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7, 5'd0,
                     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h66666666, 1'b0, 12'h341};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 12'h000, 1'b1, 5'd7,  32'h77777777, 1'b1, 5'd7,  5'd7, 5'd0,
                     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7,  32'h77777777, 1'b0, 12'h341};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 12'h000, 1'b1, 5'd7,  32'h88888888, 1'b0, 5'd0,  5'd7, 5'd0,
                     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7,  32'h88888888, 1'b0, 12'h341};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 12'h000, 1'b1, 5'd0,  32'h99999999, 1'b1, 5'd0,  5'd7, 5'd0,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h99999999, 1'b0, 12'h341};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 12'h000, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0, 5'd7,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h99999999, 1'b0, 12'h341};

        drive_idle();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_data",      wb_data,           32'd0);
        reset = 1'b0;
        #2;

        for (int i = 0; i < 11; i++) begin
            p0_valid = vecs[i].p0v;  p0_rd = vecs[i].p0rd; p0_data = vecs[i].p0d;
            p0_reg_write = vecs[i].p0rw; p0_csr_write = vecs[i].p0cw; p0_csr_addr = vecs[i].p0ca;
            p1_valid = vecs[i].p1v;  p1_rd = vecs[i].p1rd; p1_data = vecs[i].p1d;
            iss_valid = vecs[i].iv;  iss_rd = vecs[i].ird;
            q_rs1 = vecs[i].qr1;     q_rs2 = vecs[i].qr2;
            #1;
            chk($sformatf("v%0d_p0_ready", i),   32'(p0_ready),   32'(vecs[i].e_p0r));
            chk($sformatf("v%0d_p1_ready", i),   32'(p1_ready),   32'(vecs[i].e_p1r));
            chk($sformatf("v%0d_q_rs1_busy", i), 32'(q_rs1_busy), 32'(vecs[i].e_q1));
            chk($sformatf("v%0d_q_rs2_busy", i), 32'(q_rs2_busy), 32'(vecs[i].e_q2));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_wb_reg_write", i), 32'(wb_reg_write), 32'(vecs[i].e_rw));
            chk($sformatf("v%0d_fwd_valid", i),    32'(fwd_valid),    32'(vecs[i].e_rw));
            chk($sformatf("v%0d_wb_rd", i),        32'(wb_rd),        32'(vecs[i].e_rd));
            chk($sformatf("v%0d_wb_data", i),      wb_data,           vecs[i].e_d);
            chk($sformatf("v%0d_wb_csr_write", i), 32'(wb_csr_write), 32'(vecs[i].e_cw));
            chk($sformatf("v%0d_wb_csr_addr", i),  32'(wb_csr_addr),  32'(vecs[i].e_ca));
        end

        // Continuous contention: last grant was port 1, so port 0 leads and they alternate.
        drive_idle();
        p0_valid = 1'b1; p0_rd = 5'd1; p0_data = 32'h0000AAAA; p0_reg_write = 1'b1;
        p1_valid = 1'b1; p1_rd = 5'd2; p1_data = 32'h0000BBBB;
        wait0 = 0; wait1 = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_p0 = ((c % 2) == 0);
            chk($sformatf("cont%0d_p0_ready", c), 32'(p0_ready), 32'(exp_p0));
            chk($sformatf("cont%0d_p1_ready", c), 32'(p1_ready), 32'(!exp_p0));
            wait0 = p0_ready ? 0 : wait0 + 1;
            wait1 = p1_ready ? 0 : wait1 + 1;
            chk($sformatf("cont%0d_wait_le1", c), 32'((wait0 <= 1) && (wait1 <= 1)), 32'd1);
            @(posedge clock);
            #1;
            chk($sformatf("cont%0d_wb_rd", c), 32'(wb_rd), exp_p0 ? 32'd1 : 32'd2);
        end

        // Mid-cycle asynchronous reset with a pending write and a busy register.
        drive_idle();
        p0_valid = 1'b1; p0_rd = 5'd6; p0_data = 32'hAAAA5555; p0_reg_write = 1'b1;
        iss_valid = 1'b1; iss_rd = 5'd12;
        q_rs1 = 5'd12; q_rs2 = 5'd12;
        @(posedge clock);
        #1;
        drive_idle();
        chk("pre_rst_wb_reg_write", 32'(wb_reg_write), 32'd1);
        chk("pre_rst_wb_data",      wb_data,           32'hAAAA5555);
        chk("pre_rst_busy12",       32'(q_rs1_busy),   32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("async_rst_fwd_valid",    32'(fwd_valid),    32'd0);
        chk("async_rst_wb_rd",        32'(wb_rd),        32'd0);
        chk("async_rst_wb_data",      wb_data,           32'd0);
        chk("async_rst_wb_csr",       32'(wb_csr_write), 32'd0);
        chk("async_rst_wb_csr_addr",  32'(wb_csr_addr),  32'd0);
        chk("async_rst_busy12",       32'(q_rs1_busy),   32'd0);
        #1;
        reset = 1'b0;
        // Port 0 won the last grant before reset; reset must restore port-0 priority.
        p0_valid = 1'b1; p0_rd = 5'd8; p0_data = 32'h12345678; p0_reg_write = 1'b1;
        p1_valid = 1'b1; p1_rd = 5'd9; p1_data = 32'h87654321;
        #1;
        chk("post_rst_tie_p0_ready", 32'(p0_ready), 32'd1);
        chk("post_rst_tie_p1_ready", 32'(p1_ready), 32'd0);
        @(posedge clock);
        #1;
        chk("post_rst_wb_rd",   32'(wb_rd), 32'd8);
        chk("post_rst_wb_data", wb_data,    32'h12345678);
        drive_idle();
        @(posedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
